pipe_stage_reg: RTL and testbench

Parametrised, elastic pipeline-stage register for the MIPS pipeline. It replaces the fixed per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with one configurable block. Each stage carries a control field and a data field, with:
- a valid/ready handshake and a one-entry skid buffer, so back-pressure never drops a beat;
- synchronous flush that inserts a bubble with all control bits cleared;
- a saturating stall-cycle counter for performance monitoring.

---
 rtl/pipe_stage_reg.sv | 138 +++++++++++++
 tb/tb_pipe_stage_reg.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline-stage register with a one-entry skid buffer, synchronous flush
// and a saturating back-pressure counter; replaces the fixed inter-stage registers.
module pipe_stage_reg #(
    parameter int CTRL_W = 3,
    parameter int DATA_W = 69,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } stateT;

    stateT             state;
    stateT             stateNext;
    logic              inReadyQ;
    logic [CTRL_W-1:0] mCtrl;
    logic [DATA_W-1:0] mData;
    logic [CTRL_W-1:0] sCtrl;
    logic [DATA_W-1:0] sData;
    logic [CNT_W-1:0]  stallCnt;

    logic accept;
    logic drain;
    logic loadMainIn;
    logic loadMainSkid;
    logic loadSkid;

    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    assign out_valid = (state != EMPTY);
    assign accept    = in_valid & inReadyQ;
    assign drain     = out_valid & out_ready;

    always_comb begin
        stateNext    = state;
        loadMainIn   = 1'b0;
        loadMainSkid = 1'b0;
        loadSkid     = 1'b0;
        if (flush) begin
            stateNext = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        stateNext  = FULL;
                        loadMainIn = 1'b1;
                    end
                end
                FULL: begin
                    if (accept && drain) begin
                        loadMainIn = 1'b1;
                    end else if (drain) begin
                        stateNext = EMPTY;
                    end else if (accept) begin
                        stateNext = SKID;
                        loadSkid  = 1'b1;
                    end
                end
                SKID: begin
                    // in_ready is low here, so only a drain can move the state
                    if (drain) begin
                        stateNext    = FULL;
                        loadMainSkid = 1'b1;
                    end
                end
                default: stateNext = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= EMPTY;
            inReadyQ <= 1'b1;
        end else begin
            state    <= stateNext;
            inReadyQ <= (stateNext != SKID);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mCtrl <= '0;
            mData <= '0;
            sCtrl <= '0;
            sData <= '0;
        end else if (flush) begin
            mCtrl <= '0;
            sCtrl <= '0;
        end else begin
            if (loadMainIn) begin
                mCtrl <= in_ctrl;
                mData <= in_data;
            end else if (loadMainSkid) begin
                mCtrl <= sCtrl;
                mData <= sData;
            end
            if (loadSkid) begin
                sCtrl <= in_ctrl;
                sData <= in_data;
            end else if (loadMainSkid) begin
                sCtrl <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stallCnt <= '0;
        end else if (out_valid && !out_ready) begin
            stallCnt <= satInc(stallCnt);
        end
    end

    // A bubble must never present stale control bits downstream
    assign out_ctrl  = out_valid ? mCtrl : '0;
    assign out_data  = mData;
    assign in_ready  = inReadyQ;
    assign stall_cnt = stallCnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: reset, streaming, skid back-pressure, flush,
// bubble gating and stall-counter saturation (4-bit counter instance).
module tb_pipe_stage_reg;

    localparam int CTRL_W = 3;
    localparam int DATA_W = 69;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic [CNT_W-1:0]  stall_cnt;

    int compared   = 0;
    int mismatched = 0;

    pipe_stage_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d);
        in_valid = v;
        in_ctrl  = c;
        in_data  = d;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        drive(1'b0, '0, '0);
        flush     = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1;
        drive(1'b0, '0, '0);
        flush     = 1'b0;
        out_ready = 1'b0;
        #2;

        // Reset / idle
        doReset();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_ctrl",  out_ctrl,  0);
        chk("rst_out_data",  out_data,  0);
        chk("rst_in_ready",  in_ready,  1);
        chk("rst_stall_cnt", stall_cnt, 0);

        // Streaming 1..4 with ctrl 111
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 3'b111, DATA_W'(i));
            step();
            chk("stream_valid", out_valid, 1);
            chk("stream_data",  out_data,  i);
            chk("stream_ctrl",  out_ctrl,  3'b111);
            chk("stream_ready", in_ready,  1);
        end
        drive(1'b0, '0, '0);
        step();
        chk("stream_end_valid", out_valid, 0);
        chk("stream_end_ctrl",  out_ctrl,  0);
        chk("stream_stall",     stall_cnt, 0);

        // Back-pressure: A on outputs, out_ready low for 3 edges
        doReset();
        out_ready = 1'b1;
        drive(1'b1, 3'b001, 69'hA);
        step();
        chk("bp_A_out", out_data, 69'hA);
        out_ready = 1'b0;
        drive(1'b1, 3'b010, 69'hB);
        step();
        chk("bp_skid_hold_A", out_data, 69'hA);
        chk("bp_in_ready_low", in_ready, 0);
        chk("bp_stall1", stall_cnt, 1);
        drive(1'b1, 3'b011, 69'hC);
        step();
        chk("bp_hold2_A", out_data, 69'hA);
        chk("bp_stall2", stall_cnt, 2);
        step();
        chk("bp_hold3_A", out_data, 69'hA);
        chk("bp_hold3_ctrl", out_ctrl, 3'b001);
        chk("bp_in_ready_still_low", in_ready, 0);
        chk("bp_stall3", stall_cnt, 3);
        out_ready = 1'b1;
        step();
        chk("bp_B_out", out_data, 69'hB);
        chk("bp_B_ctrl", out_ctrl, 3'b010);
        chk("bp_recover_ready", in_ready, 1);
        step();
        chk("bp_C_out", out_data, 69'hC);
        chk("bp_C_valid", out_valid, 1);
        drive(1'b1, 3'b100, 69'hD);
        step();
        chk("bp_D_out", out_data, 69'hD);
        drive(1'b0, '0, '0);
        step();
        chk("bp_end_valid", out_valid, 0);
        chk("bp_stall_final", stall_cnt, 3);

        // Flush in SKID with C presented
        doReset();
        out_ready = 1'b1;
        drive(1'b1, 3'b111, 69'hA);
        step();
        out_ready = 1'b0;
        drive(1'b1, 3'b111, 69'hB);
        step();
        chk("fl_skid_ready", in_ready, 0);
        drive(1'b1, 3'b111, 69'hC);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fl_valid", out_valid, 0);
        chk("fl_ctrl",  out_ctrl,  0);
        chk("fl_ready", in_ready,  1);
        drive(1'b0, '0, '0);
        step();
        chk("fl_C_dropped", out_valid, 0);
        out_ready = 1'b1;
        drive(1'b1, 3'b101, 69'hE);
        step();
        chk("fl_E_valid", out_valid, 1);
        chk("fl_E_data",  out_data,  69'hE);
        chk("fl_E_ctrl",  out_ctrl,  3'b101);
        drive(1'b0, '0, '0);
        step();
        chk("fl_E_gone", out_valid, 0);

        // Bubble gating
        drive(1'b1, 3'b110, 69'h55);
        step();
        chk("bub_ctrl_live", out_ctrl, 3'b110);
        drive(1'b0, '0, '0);
        step();
        chk("bub_valid", out_valid, 0);
        chk("bub_ctrl_gated", out_ctrl, 0);

        // Counter saturation
        doReset();
        out_ready = 1'b0;
        drive(1'b1, 3'b001, 69'h1F);
        step();
        drive(1'b0, '0, '0);
        repeat (14) step();
        chk("sat_cnt14", stall_cnt, 14);
        repeat (6) step();
        chk("sat_cnt15", stall_cnt, 15);
        out_ready = 1'b1;
        step();
        chk("sat_after_drain", stall_cnt, 15);
        chk("sat_drained", out_valid, 0);

        // Asynchronous reset mid-cycle with a beat held
        out_ready = 1'b0;
        drive(1'b1, 3'b011, 69'h77);
        step();
        drive(1'b0, '0, '0);
        chk("ar_loaded", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", out_valid, 0);
        chk("ar_ctrl",  out_ctrl,  0);
        chk("ar_data",  out_data,  0);
        chk("ar_stall", stall_cnt, 0);
        chk("ar_ready", in_ready,  1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
